// File: rtl/dram_arb_phy.sv
// dram_arb_phy: word-addressed on-chip RAM model shared by NUM_CH request
// channels. Round-robin arbitration with valid/ready handshakes, byte-masked
// writes and a fixed RD_LAT read-return pipeline tagged by channel.
module dram_arb_phy #(
  parameter int RAM_SIZE_KB = 1,
  parameter int RAM_ADDR    = 22,
  parameter int RAM_DWIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int RD_LAT      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req_valid,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0]              req_we,
  input  logic [NUM_CH*RAM_DWIDTH/8-1:0] req_be,
  input  logic [NUM_CH*RAM_ADDR-1:0]     req_addr,
  input  logic [NUM_CH*RAM_DWIDTH-1:0]   req_din,
  output logic [RAM_DWIDTH-1:0]          rd_dout,
  output logic [NUM_CH-1:0]              rd_valid
);

  localparam int DEPTH = RAM_SIZE_KB * 8192 / RAM_DWIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTE = RAM_DWIDTH / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [RAM_DWIDTH-1:0] r_mem [DEPTH];

  logic [CH_W-1:0]       r_ptr;
  logic [NUM_CH-1:0]     r_rd_valid;
  logic [RAM_DWIDTH-1:0] r_rd_dout;

  logic                  w_grant_any;
  logic [CH_W-1:0]       w_grant_idx;
  logic [CH_W:0]         w_scan;

  logic                  w_sel_we;
  logic [NBYTE-1:0]      w_sel_be;
  logic [RAM_ADDR-1:0]   w_sel_addr;
  logic [RAM_DWIDTH-1:0] w_sel_din;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_acc_wr;
  logic                  w_acc_rd;

  logic                  w_out_v;
  logic [CH_W-1:0]       w_out_tag;
  logic [RAM_DWIDTH-1:0] w_out_d;

  // Round-robin search from r_ptr upward, wrapping at NUM_CH; no grant in reset
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_scan = {1'b0, r_ptr} + (CH_W+1)'(k);
      if (w_scan >= (CH_W+1)'(NUM_CH)) begin
        w_scan = w_scan - (CH_W+1)'(NUM_CH);
      end
      if (!w_grant_any && req_valid[w_scan[CH_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan[CH_W-1:0];
      end
    end
    if (rst) begin
      w_grant_any = 1'b0;
    end
  end

  assign req_ready = w_grant_any ? (NUM_CH'(1) << w_grant_idx) : '0;

  // Route the granted channel's request fields to the shared datapath
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_be   = '0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant_idx == CH_W'(i)) begin
        w_sel_we   = req_we[i];
        w_sel_be   = req_be[i*NBYTE +: NBYTE];
        w_sel_addr = req_addr[i*RAM_ADDR +: RAM_ADDR];
        w_sel_din  = req_din[i*RAM_DWIDTH +: RAM_DWIDTH];
      end
    end
  end

  // Upper address bits are ignored so accesses wrap modulo DEPTH
  assign w_idx    = w_sel_addr[IDX_W-1:0];
  assign w_acc_wr = w_grant_any &  w_sel_we;
  assign w_acc_rd = w_grant_any & ~w_sel_we;

  generate
    if (RAM_ADDR > IDX_W) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^w_sel_addr[RAM_ADDR-1:IDX_W];
    end
  endgenerate

  // Byte-masked write; the array has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (w_sel_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_sel_din[b*8 +: 8];
        end
      end
    end
  end

  // Pointer moves past the granted channel on every acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      if (w_grant_idx == CH_W'(NUM_CH - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grant_idx + CH_W'(1);
      end
    end
  end

  // With RD_LAT=1 the output register is loaded straight from the array;
  // otherwise RD_LAT-1 tagged stages sit in front of it.
  generate
    if (RD_LAT == 1) begin : g_direct
      assign w_out_v   = w_acc_rd;
      assign w_out_tag = w_grant_idx;
      assign w_out_d   = r_mem[w_idx];
    end else begin : g_pipe
      localparam int STG = RD_LAT - 1;
      logic                  r_pv   [STG];
      logic [CH_W-1:0]       r_ptag [STG];
      logic [RAM_DWIDTH-1:0] r_pd   [STG];

      // Stage 0 samples the array at acceptance; later stages shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < STG; s++) begin
            r_pv[s]   <= 1'b0;
            r_ptag[s] <= '0;
            r_pd[s]   <= '0;
          end
        end else begin
          r_pv[0]   <= w_acc_rd;
          r_ptag[0] <= w_grant_idx;
          r_pd[0]   <= r_mem[w_idx];
          for (int s = 1; s < STG; s++) begin
            r_pv[s]   <= r_pv[s-1];
            r_ptag[s] <= r_ptag[s-1];
            r_pd[s]   <= r_pd[s-1];
          end
        end
      end

      assign w_out_v   = r_pv[STG-1];
      assign w_out_tag = r_ptag[STG-1];
      assign w_out_d   = r_pd[STG-1];
    end
  endgenerate

  // One-cycle rd_valid pulse per return; rd_dout holds between returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= '0;
      r_rd_dout  <= '0;
    end else if (w_out_v) begin
      r_rd_valid <= NUM_CH'(1) << w_out_tag;
      r_rd_dout  <= w_out_d;
    end else begin
      r_rd_valid <= '0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_dout  = r_rd_dout;

endmodule

// File: tb/tb_dram_arb_phy.sv
// Bench for dram_arb_phy: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a queue-based reference model.
module tb_dram_arb_phy;

  localparam int NUM_CH      = 2;
  localparam int RAM_ADDR    = 22;
  localparam int RAM_DWIDTH  = 32;
  localparam int RD_LAT      = 2;
  localparam int RAM_SIZE_KB = 1;
  localparam int DEPTH       = 256;
  localparam int NBYTE       = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH-1:0]            req_we;
  logic [NUM_CH*NBYTE-1:0]      req_be;
  logic [NUM_CH*RAM_ADDR-1:0]   req_addr;
  logic [NUM_CH*RAM_DWIDTH-1:0] req_din;
  logic [RAM_DWIDTH-1:0]        rd_dout;
  logic [NUM_CH-1:0]            rd_valid;

  dram_arb_phy #(
    .RAM_SIZE_KB(RAM_SIZE_KB), .RAM_ADDR(RAM_ADDR), .RAM_DWIDTH(RAM_DWIDTH),
    .NUM_CH(NUM_CH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_din(req_din),
    .rd_dout(rd_dout), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  typedef struct { int due; int ch; logic [31:0] data; } ret_t;
  logic [31:0] m_mem [DEPTH];
  int          m_ptr  = 0;
  logic [31:0] m_last = '0;
  ret_t        m_q [$];

  // logs of what the DUT did (filled by the checker, read by directed steps)
  int          obs_ch [$];
  int          obs_e  [$];
  logic [31:0] obs_d  [$];
  int          acc_ch [$];
  int          acc_e  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NUM_CH-1:0] v, input int p);
    for (int k = 0; k < NUM_CH; k++) begin
      if (v[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    end
    return -1;
  endfunction

  // Cycle checker: returns due this cycle, grant choice, model update
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_v, exp_r;
    logic [31:0]       exp_d, din;
    logic [21:0]       a;
    logic [3:0]        be;
    int                g, ix;
    if (rst) begin
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rd_valid", rd_valid, '0);
      chk("rst_rd_dout", rd_dout, '0);
      m_q.delete();
      m_ptr  = 0;
      m_last = '0;
    end else begin
      exp_v = '0;
      exp_d = m_last;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        exp_v  = NUM_CH'(1) << m_q[0].ch;
        exp_d  = m_q[0].data;
        m_last = exp_d;
        void'(m_q.pop_front());
      end
      chk("rd_valid", rd_valid, exp_v);
      chk("rd_dout", rd_dout, exp_d);
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_valid[c] === 1'b1) begin
          obs_ch.push_back(c);
          obs_d.push_back(rd_dout);
          obs_e.push_back(cyc);
        end
      end
      g     = model_grant(req_valid, m_ptr);
      exp_r = (g >= 0) ? (NUM_CH'(1) << g) : '0;
      chk("req_ready", req_ready, exp_r);
      if (g >= 0) begin
        a   = req_addr[g*RAM_ADDR +: RAM_ADDR];
        be  = req_be[g*NBYTE +: NBYTE];
        din = req_din[g*RAM_DWIDTH +: RAM_DWIDTH];
        ix  = int'(a) % DEPTH;
        if (req_we[g]) begin
          for (int b = 0; b < NBYTE; b++) begin
            if (be[b]) m_mem[ix][b*8 +: 8] = din[b*8 +: 8];
          end
        end else begin
          m_q.push_back('{cyc + RD_LAT, g, m_mem[ix]});
        end
        acc_ch.push_back(g);
        acc_e.push_back(cyc + 1);
        m_ptr = (g + 1) % NUM_CH;
      end
    end
  end

  task automatic issue(input int ch, input bit we, input logic [3:0] be,
                       input logic [21:0] addr, input logic [31:0] din);
    bit done;
    done = 1'b0;
    req_we[ch]                    = we;
    req_be[ch*NBYTE +: NBYTE]     = be;
    req_addr[ch*RAM_ADDR +: RAM_ADDR] = addr;
    req_din[ch*RAM_DWIDTH +: RAM_DWIDTH] = din;
    req_valid[ch]                 = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req_ready[ch] === 1'b1) done = 1'b1;
    end
    if (!done) chk("issue_timeout", req_ready[ch], 1'b1);
    @(posedge clk);
    #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Checks log entry i against a channel and data word
  task automatic chk_ret(input string tag, input int i, input int ech, input logic [31:0] ed);
    if (i < obs_d.size()) begin
      chk({tag, "_ch"}, obs_ch[i], ech);
      chk({tag, "_data"}, obs_d[i], ed);
    end else begin
      chk({tag, "_missing"}, obs_d.size(), i + 1);
    end
  endtask

  function automatic int obs_edge(input int i);
    return (i < obs_e.size()) ? obs_e[i] : -1000;
  endfunction

  function automatic int acc_edge(input int i);
    return (i < acc_e.size()) ? acc_e[i] : -2000;
  endfunction

  initial begin
    int n0, a0;
    logic [NUM_CH-1:0] acc;
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_be    = '0;
    req_addr  = '0;
    req_din   = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;

    // single channel writes then back-to-back reads
    issue(0, 1'b1, 4'hF, 22'd1, 32'h11223344);
    issue(0, 1'b1, 4'hF, 22'd2, 32'habcdef12);
    issue(0, 1'b1, 4'hF, 22'd3, 32'h01234567);
    n0 = obs_d.size();
    a0 = acc_e.size();
    issue(0, 1'b0, 4'h0, 22'd1, 32'h0);
    issue(0, 1'b0, 4'h0, 22'd2, 32'h0);
    issue(0, 1'b0, 4'h0, 22'd3, 32'h0);
    idle(RD_LAT + 3);
    chk("t1_count", obs_d.size() - n0, 3);
    chk_ret("t1_r0", n0,     0, 32'h11223344);
    chk_ret("t1_r1", n0 + 1, 0, 32'habcdef12);
    chk_ret("t1_r2", n0 + 2, 0, 32'h01234567);
    chk("t1_latency", obs_edge(n0) - acc_edge(a0), RD_LAT - 1);
    chk("t1_b2b_a", obs_edge(n0 + 1) - obs_edge(n0), 1);
    chk("t1_b2b_b", obs_edge(n0 + 2) - obs_edge(n0 + 1), 1);

    // byte enables
    issue(0, 1'b1, 4'hF, 22'd5, 32'hAABBCCDD);
    issue(0, 1'b1, 4'h5, 22'd5, 32'h11223344);
    n0 = obs_d.size();
    issue(0, 1'b0, 4'h0, 22'd5, 32'h0);
    idle(RD_LAT + 2);
    chk_ret("t2_be", n0, 0, 32'hAA22CC44);

    // be=0 is a no-op write that still takes a grant
    a0 = acc_e.size();
    issue(1, 1'b1, 4'h0, 22'd5, 32'h99999999);
    chk("t2_be0_grant", acc_e.size() - a0, 1);
    n0 = obs_d.size();
    issue(0, 1'b0, 4'h0, 22'd5, 32'h0);
    idle(RD_LAT + 2);
    chk_ret("t2_be0", n0, 0, 32'hAA22CC44);

    // arbitration: both channels hold valid reads, ptr reset to 0
    reset_dut(2);
    n0 = obs_d.size();
    a0 = acc_ch.size();
    req_we   = '0;
    req_addr = {22'd2, 22'd1};
    req_valid = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    req_valid = '0;
    idle(RD_LAT + 2);
    chk("t3_acc_count", acc_ch.size() - a0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", (a0 + i < acc_ch.size()) ? acc_ch[a0 + i] : -1, i % 2);
      chk_ret("t3_ret", n0 + i, i % 2, (i % 2 == 0) ? 32'h11223344 : 32'habcdef12);
    end
    chk("t3_b2b", obs_edge(n0 + 3) - obs_edge(n0), 3);

    // address wrap-around modulo DEPTH
    issue(1, 1'b1, 4'hF, 22'h000105, 32'hDEADBEEF);
    n0 = obs_d.size();
    issue(0, 1'b0, 4'h0, 22'h000005, 32'h0);
    idle(RD_LAT + 2);
    chk_ret("t4_wrap", n0, 0, 32'hDEADBEEF);

    // read-after-write on consecutive edges from different channels
    a0 = acc_e.size();
    issue(1, 1'b1, 4'hF, 22'd9, 32'h00000055);
    n0 = obs_d.size();
    issue(0, 1'b0, 4'h0, 22'd9, 32'h0);
    idle(RD_LAT + 2);
    chk("t5_edges", acc_edge(a0 + 1) - acc_edge(a0), 1);
    chk_ret("t5_raw", n0, 0, 32'h00000055);

    // reset mid-operation: in-flight read dropped, ptr back to 0
    issue(0, 1'b0, 4'h0, 22'd3, 32'h0);
    n0 = obs_d.size();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(RD_LAT + 2);
    chk("t6_no_return", obs_d.size(), n0);
    req_we    = '0;
    req_addr  = {22'd2, 22'd1};
    req_valid = 2'b11;
    @(negedge clk);
    chk("t6_ptr_zero", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = '0;
    idle(RD_LAT + 2);
    chk_ret("t6_data_kept", n0, 0, 32'h11223344);

    // fill the whole array so random reads always hit known data
    for (int a = 0; a < DEPTH; a++) begin
      issue(a % NUM_CH, 1'b1, 4'hF, 22'(a), $urandom);
    end

    // randomized traffic with occasional resets, checked by the model
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(63) == 0) rst = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!req_valid[c] || acc[c]) begin
          if ($urandom_range(3) == 0) begin
            req_valid[c] = 1'b0;
          end else begin
            req_valid[c]                  = 1'b1;
            req_we[c]                     = 1'($urandom_range(1));
            req_be[c*NBYTE +: NBYTE]      = 4'($urandom);
            req_addr[c*RAM_ADDR +: RAM_ADDR] = 22'($urandom);
            req_din[c*RAM_DWIDTH +: RAM_DWIDTH] = $urandom;
          end
        end
      end
    end
    req_valid = '0;
    rst       = 1'b0;
    idle(RD_LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
